// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: sequencing controller for the calculator operand/result path.
//   Raw buttons -> 2-flop sync -> per-button debouncer lane -> prioritised
//   press -> operand-entry / compute FSM driving the A/B operand registers.
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-low reset
//   btn_up/next/op/eq/clr  raw active-high buttons (async to clk)
//   state[5:0]    state code to operand registers (0..13)
//   U             one-cycle increment strobe
//   rst_o         one-cycle operand-register clear strobe
//   op[1:0]       0 ADD, 1 SUB, 2 MUL
//   result_valid  high while in S_SUM
// Optional feature: define CALC_AUTOREPEAT_EN to auto-repeat a held btn_up.

// One button lane: counts consecutive cycles of the level it is waiting for.
// Armed lanes wait for DBNC_CYCLES highs (then fire and disarm); disarmed
// lanes wait for DBNC_CYCLES lows (then re-arm). Reset leaves lanes disarmed
// so a button held through reset must be released first.
module calc_btn_lane #(
  parameter int DBNC_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_lvl,
  output logic o_press
);
  localparam int CW = $clog2(DBNC_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DBNC_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_armed;
  logic          r_press;
  logic          w_match;

  assign w_match = r_armed ? i_lvl : ~i_lvl;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (!w_match) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_cnt   <= '0;
        r_armed <= ~r_armed;
        r_press <= r_armed;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;
endmodule

module calc_seq_ctrl #(
  parameter int DBNC_CYCLES = 4,
  parameter int REP_DELAY   = 64,
  parameter int REP_PERIOD  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_next,
  input  logic       btn_op,
  input  logic       btn_eq,
  input  logic       btn_clr,
  output logic [5:0] state,
  output logic       U,
  output logic       rst_o,
  output logic [1:0] op,
  output logic       result_valid
);
  localparam int NB = 5;  // lane index: 0 up, 1 next, 2 op, 3 eq, 4 clr
  localparam logic [3:0] S_START = 4'd0,  S_SET_A = 4'd1,  S_SET_A_THUN = 4'd4,
                         S_SET_B = 4'd5,  S_SET_B_THUN = 4'd8,
                         S_ADD   = 4'd9,  S_SUB = 4'd10, S_SSUM = 4'd11,
                         S_MUL   = 4'd12, S_ALU = 4'd13;

  logic [NB-1:0] w_raw, r_sync1, r_sync2, w_press;
  logic [3:0]    r_state, w_state_nxt;
  logic [1:0]    r_op, w_op_nxt;
  logic          r_u, w_u_nxt, r_rsto, w_rsto_nxt;
  logic          w_in_a, w_in_b, w_in_set, w_up_evt, w_rep_press;

  assign w_raw = {btn_clr, btn_eq, btn_op, btn_next, btn_up};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  calc_btn_lane #(.DBNC_CYCLES(DBNC_CYCLES)) u_lane [NB-1:0] (
    .clk(clk), .rst(rst), .i_lvl(r_sync2), .o_press(w_press)
  );

  assign w_in_a   = (r_state >= S_SET_A) && (r_state <= S_SET_A_THUN);
  assign w_in_b   = (r_state >= S_SET_B) && (r_state <= S_SET_B_THUN);
  assign w_in_set = w_in_a | w_in_b;
  assign w_up_evt = w_press[0] | w_rep_press;

`ifdef CALC_AUTOREPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);
  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_act;

  assign w_rep_press = r_rep_act && (r_rep_cnt == '0);

  // Armed by every accepted up (U strobe); first gap REP_DELAY, then
  // REP_PERIOD. A repeat held off by a higher-priority press stays pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rep_act <= 1'b0;
      r_rep_cnt <= '0;
    end else if (!r_sync2[0] || !w_in_set || (w_state_nxt != r_state)) begin
      r_rep_act <= 1'b0;
    end else if (w_u_nxt) begin
      r_rep_act <= 1'b1;
      r_rep_cnt <= (w_rep_press && !w_press[0]) ? RW'(REP_PERIOD - 1)
                                                 : RW'(REP_DELAY - 1);
    end else if (r_rep_act && (r_rep_cnt != '0)) begin
      r_rep_cnt <= r_rep_cnt - 1'b1;
    end
  end
`else
  assign w_rep_press = 1'b0;
  // Repeat timing parameters have no effect in this build.
  if ((REP_DELAY < 1) || (REP_PERIOD < 1)) begin : g_rep_cfg
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_START;
      r_op    <= 2'd0;
      r_u     <= 1'b0;
      r_rsto  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_u     <= w_u_nxt;
      r_rsto  <= w_rsto_nxt;
    end
  end

  // Next-state: automatic compute walk first, then at most one press,
  // highest priority first (clr > eq > op > next > up).
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_u_nxt     = 1'b0;
    w_rsto_nxt  = 1'b0;
    if (r_state > S_ALU)                                   w_state_nxt = S_START;
    else if (r_state == S_ALU)                             w_state_nxt = S_SSUM;
    else if ((r_state == S_ADD) || (r_state == S_SUB) ||
             (r_state == S_MUL))                           w_state_nxt = S_ALU;

    if (w_press[4]) begin
      w_state_nxt = S_START;
      w_rsto_nxt  = 1'b1;
      w_op_nxt    = 2'd0;
    end else if (w_press[3]) begin
      if (w_in_b) begin
        case (r_op)
          2'd1:    w_state_nxt = S_SUB;
          2'd2:    w_state_nxt = S_MUL;
          default: w_state_nxt = S_ADD;
        endcase
      end
    end else if (w_press[2]) begin
      if (w_in_a)      w_state_nxt = S_SET_B;
      else if (w_in_b) w_op_nxt    = (r_op == 2'd2) ? 2'd0 : r_op + 2'd1;
    end else if (w_press[1]) begin
      if (r_state == S_START) begin
        w_state_nxt = S_SET_A;
      end else if (w_in_a) begin
        w_state_nxt = (r_state == S_SET_A_THUN) ? S_SET_A : r_state + 4'd1;
      end else if (w_in_b) begin
        w_state_nxt = (r_state == S_SET_B_THUN) ? S_SET_B : r_state + 4'd1;
      end else if (r_state == S_SSUM) begin
        w_state_nxt = S_SET_A;
        w_rsto_nxt  = 1'b1;
        w_op_nxt    = 2'd0;
      end
    end else if (w_up_evt) begin
      w_u_nxt = w_in_set;
    end
  end

  // Outputs
  always_comb begin
    state        = {2'b00, r_state};
    U            = r_u;
    rst_o        = r_rsto;
    op           = r_op;
    result_valid = (r_state == S_SSUM);
  end
endmodule

// File: tb/tb_calc_seq_ctrl.sv
module tb_calc_seq_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic btn_up = 1'b0, btn_next = 1'b0, btn_op = 1'b0, btn_eq = 1'b0, btn_clr = 1'b0;
  logic [5:0] state;
  logic       U, rst_o, result_valid;
  logic [1:0] op;
  int checks = 0, errors = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [5:0] st; logic u; logic ro; logic [1:0] op; logic rv;
  } obs_t;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  calc_seq_ctrl #(.DBNC_CYCLES(4), .REP_DELAY(64), .REP_PERIOD(16)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_next(btn_next), .btn_op(btn_op),
    .btn_eq(btn_eq), .btn_clr(btn_clr), .state(state), .U(U), .rst_o(rst_o),
    .op(op), .result_valid(result_valid)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int st, input bit u, input bit ro, input int o, input bit rv);
    obs_t e;
    e.st = 6'(st); e.u = u; e.ro = ro; e.op = 2'(o); e.rv = rv;
    exp_q.push_back(e);
  endtask

  task automatic set_btn(input int b, input bit v);
    case (b)
      0: btn_up = v;
      1: btn_next = v;
      2: btn_op = v;
      3: btn_eq = v;
      default: btn_clr = v;
    endcase
  endtask

  // 8 cycles high (fires at 7), 10 low (re-arms after sync + 4 lows)
  task automatic press(input int b);
    set_btn(b, 1'b1); cyc(8);
    set_btn(b, 1'b0); cyc(10);
  endtask

  // Scoreboard side: every cycle with a state/op change or a strobe is an event
  task automatic monitor();
    logic [5:0] pst; logic [1:0] pop; obs_t cur, e;
    pst = '0; pop = '0;
    forever begin
      @(negedge clk);
      if (mon_en && (state !== pst || op !== pop || U !== 1'b0 || rst_o !== 1'b0)) begin
        cur = {state, U, rst_o, op, result_valid};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event_unexpected: got st=%0d U=%0b rst_o=%0b op=%0d rv=%0b, required no event",
                   cur.st, cur.u, cur.ro, cur.op, cur.rv);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL event_mismatch: got st=%0d U=%0b rst_o=%0b op=%0d rv=%0b, required st=%0d U=%0b rst_o=%0b op=%0d rv=%0b",
                     cur.st, cur.u, cur.ro, cur.op, cur.rv, e.st, e.u, e.ro, e.op, e.rv);
          end
        end
      end
      pst = state; pop = op;
    end
  endtask

  task automatic test_reset();
    btn_up = 1'b1;
    cyc(3);
    @(negedge clk);
    checks++; if (state !== 6'd0)       begin errors++; $display("FAIL reset_state: got %0d, required 0", state); end
    checks++; if (U !== 1'b0)           begin errors++; $display("FAIL reset_U: got %0b, required 0", U); end
    checks++; if (rst_o !== 1'b0)       begin errors++; $display("FAIL reset_rst_o: got %0b, required 0", rst_o); end
    checks++; if (op !== 2'd0)          begin errors++; $display("FAIL reset_op: got %0d, required 0", op); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %0b, required 0", result_valid); end
    btn_up = 1'b0;
    cyc(1);
    rst = 1'b1;
    mon_en = 1'b1;
    cyc(10);
  endtask

  task automatic test_up_in_start();
    btn_up = 1'b1; cyc(20);
    btn_up = 1'b0; cyc(10);
    checks++; if (state !== 6'd0) begin errors++; $display("FAIL up_in_start: got state %0d, required 0", state); end
  endtask

  task automatic test_set_a();
    int n;
    push(1, 0, 0, 0, 0);
    btn_next = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1; n++;
      if (state === 6'd1) break;
    end
    checks++; if (n !== 7) begin errors++; $display("FAIL latency: got %0d cycles, required 7", n); end
    cyc(1); btn_next = 1'b0; cyc(10);
    for (int i = 0; i < 3; i++) begin
      push(1, 1, 0, 0, 0);
      press(0);
    end
    checks++; if (state !== 6'd1 || U !== 1'b0) begin
      errors++; $display("FAIL up_in_set_a: got state %0d U %0b, required 1 0", state, U);
    end
  endtask

  task automatic test_digits();
    push(2, 0, 0, 0, 0); press(1);
    push(3, 0, 0, 0, 0); press(1);
    push(4, 0, 0, 0, 0); press(1);
    push(1, 0, 0, 0, 0); press(1);
    push(5, 0, 0, 0, 0); press(2);
    checks++; if (state !== 6'd5 || op !== 2'd0) begin
      errors++; $display("FAIL enter_b: got state %0d op %0d, required 5 0", state, op);
    end
  endtask

  task automatic test_op_eq();
    int n;
    push(5, 0, 0, 1, 0); press(2);
    push(5, 0, 0, 2, 0); press(2);
    push(12, 0, 0, 2, 0); push(13, 0, 0, 2, 0); push(11, 0, 0, 2, 1);
    btn_eq = 1'b1;
    n = 0;
    while (n < 20 && state !== 6'd12) begin @(posedge clk); #1; n++; end
    checks++; if (state !== 6'd12) begin errors++; $display("FAIL eq_timeout: got state %0d, required 12", state); end
    cyc(1);
    checks++; if (state !== 6'd13) begin errors++; $display("FAIL mul_dwell: got state %0d, required 13", state); end
    cyc(1);
    checks++; if (state !== 6'd11 || result_valid !== 1'b1) begin
      errors++; $display("FAIL alu_dwell: got state %0d rv %0b, required 11 1", state, result_valid);
    end
    btn_eq = 1'b0; cyc(10);
    press(3);  // eq in S_SUM is ignored
    cyc(5);
    checks++; if (state !== 6'd11 || result_valid !== 1'b1 || op !== 2'd2) begin
      errors++; $display("FAIL sum_hold: got state %0d rv %0b op %0d, required 11 1 2", state, result_valid, op);
    end
  endtask

  task automatic test_clr_eq();
    int n;
    push(1, 0, 1, 0, 0); press(1);  // next from S_SUM clears operands
    push(5, 0, 0, 0, 0); press(2);
    push(6, 0, 0, 0, 0); press(1);
    push(6, 0, 0, 1, 0); press(2);
    push(0, 0, 1, 0, 0);
    btn_clr = 1'b1; btn_eq = 1'b1;
    n = 0;
    while (n < 20 && state !== 6'd0) begin @(posedge clk); #1; n++; end
    checks++; if (state !== 6'd0 || rst_o !== 1'b1) begin
      errors++; $display("FAIL clr_eq: got state %0d rst_o %0b, required 0 1", state, rst_o);
    end
    cyc(1);
    checks++; if (rst_o !== 1'b0) begin errors++; $display("FAIL clr_pulse_len: got rst_o %0b, required 0", rst_o); end
    btn_clr = 1'b0; btn_eq = 1'b0; cyc(10);
    checks++; if (state !== 6'd0 || op !== 2'd0) begin
      errors++; $display("FAIL clr_after: got state %0d op %0d, required 0 0", state, op);
    end
  endtask

  task automatic test_glitch();
    btn_next = 1'b1; cyc(3);
    btn_next = 1'b0; cyc(15);
    checks++; if (state !== 6'd0) begin errors++; $display("FAIL glitch: got state %0d, required 0", state); end
  endtask

  task automatic test_reset_hold();
    int n;
    btn_next = 1'b1; cyc(2);
    rst = 1'b0; cyc(3);
    rst = 1'b1; cyc(20);
    checks++; if (state !== 6'd0) begin errors++; $display("FAIL held_through_reset: got state %0d, required 0", state); end
    btn_next = 1'b0; cyc(4);
    push(1, 0, 0, 0, 0);
    btn_next = 1'b1; cyc(4);
    btn_next = 1'b0;
    n = 0;
    while (n < 12 && state !== 6'd1) begin @(posedge clk); #1; n++; end
    checks++; if (state !== 6'd1) begin errors++; $display("FAIL rearm_press: got state %0d, required 1", state); end
    cyc(10);
  endtask

  task automatic test_reset_abort();
    push(0, 0, 0, 0, 0);
    btn_up = 1'b1; cyc(5);
    rst = 1'b0; cyc(2);
    btn_up = 1'b0; rst = 1'b1; cyc(12);
    checks++; if (state !== 6'd0 || U !== 1'b0) begin
      errors++; $display("FAIL reset_abort: got state %0d U %0b, required 0 0", state, U);
    end
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_up_in_start();
    test_set_a();
    test_digits();
    test_op_eq();
    test_clr_eq();
    test_glitch();
    test_reset_hold();
    test_reset_abort();
    cyc(3);
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending events, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
